// File: rtl/fb_arbiter.sv
// Single-port frame-buffer arbiter: display has absolute priority, edge and load
// share the remaining slots round-robin, and read data is steered back by owner tag.
module fb_arbiter #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              edge_req,
    input  logic              edge_we,
    input  logic [ADDR_W-1:0] edge_addr,
    input  logic [DATA_W-1:0] edge_wdata,
    output logic              edge_gnt,
    output logic              edge_rvalid,
    output logic [DATA_W-1:0] edge_rdata,
    input  logic              load_req,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_wdata,
    output logic              load_gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              rr;
    logic              any_gnt;
    logic              rd_issue;
    logic [RD_LAT:0]   vld_p;
    logic [RD_LAT:0]   own_p;

    // Grant decision: rr=0 favours edge, rr=1 favours load
    always_comb begin
        disp_gnt = 1'b0;
        edge_gnt = 1'b0;
        load_gnt = 1'b0;
        if (!rst) begin
            if (disp_req)
                disp_gnt = 1'b1;
            else if (edge_req && (!load_req || !rr))
                edge_gnt = 1'b1;
            else if (load_req)
                load_gnt = 1'b1;
        end
    end

    assign any_gnt  = disp_gnt | edge_gnt | load_gnt;
    assign rd_issue = disp_gnt | (edge_gnt & ~edge_we);

    always_ff @(posedge clk) begin
        if (rst)
            rr <= 1'b0;
        else if (edge_gnt)
            rr <= 1'b1;
        else if (load_gnt)
            rr <= 1'b0;
    end

    // Command stage (p0): granted request drives the SRAM port one cycle after gnt
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= any_gnt;
            mem_we <= load_gnt | (edge_gnt & edge_we);
            if (disp_gnt) begin
                mem_addr <= disp_addr;
            end else if (edge_gnt) begin
                mem_addr  <= edge_addr;
                mem_wdata <= edge_wdata;
            end else if (load_gnt) begin
                mem_addr  <= load_addr;
                mem_wdata <= load_wdata;
            end
        end
    end

    // Tag pipeline p0..pRD_LAT: stage RD_LAT lines up with valid mem_rdata
    always_ff @(posedge clk) begin
        if (rst)
            vld_p <= '0;
        else
            vld_p <= {vld_p[RD_LAT-1:0], rd_issue};
        own_p <= {own_p[RD_LAT-1:0], edge_gnt};
    end

    // Return stage: capture read data into the owning requester
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_rvalid <= 1'b0;
            edge_rvalid <= 1'b0;
            disp_rdata  <= '0;
            edge_rdata  <= '0;
        end else begin
            disp_rvalid <= vld_p[RD_LAT] & ~own_p[RD_LAT];
            edge_rvalid <= vld_p[RD_LAT] & own_p[RD_LAT];
            if (vld_p[RD_LAT] && !own_p[RD_LAT])
                disp_rdata <= mem_rdata;
            if (vld_p[RD_LAT] && own_p[RD_LAT])
                edge_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model of the arbiter.
module tb_fb_arbiter;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 1;
    localparam int MEMSZ  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              disp_req, edge_req, edge_we, load_req;
    logic [ADDR_W-1:0] disp_addr, edge_addr, load_addr;
    logic [DATA_W-1:0] edge_wdata, load_wdata;
    logic              disp_gnt, edge_gnt, load_gnt;
    logic              disp_rvalid, edge_rvalid;
    logic [DATA_W-1:0] disp_rdata, edge_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .edge_req(edge_req), .edge_we(edge_we), .edge_addr(edge_addr),
        .edge_wdata(edge_wdata), .edge_gnt(edge_gnt),
        .edge_rvalid(edge_rvalid), .edge_rdata(edge_rdata),
        .load_req(load_req), .load_addr(load_addr), .load_wdata(load_wdata),
        .load_gnt(load_gnt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // SRAM with RD_LAT-cycle read latency
    logic [DATA_W-1:0] sram [0:MEMSZ-1];
    logic [DATA_W-1:0] rpipe [0:RD_LAT-1];
    always @(posedge clk) begin
        if (mem_en && mem_we)
            sram[mem_addr] <= mem_wdata;
        rpipe[0] <= sram[mem_addr];
        for (int i = 1; i < RD_LAT; i++)
            rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata = rpipe[RD_LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the requesters should observe
    typedef struct {
        int               due;
        bit               to_edge;
        logic [DATA_W-1:0] data;
    } ret_t;

    logic [DATA_W-1:0] ref_mem [0:MEMSZ-1];
    ret_t              rq[$];
    bit                started = 0;
    int                ncyc = 0;
    bit                edge_served_last = 0;
    bit                x_en = 0, x_we = 0;
    logic [ADDR_W-1:0] x_addr = '0;
    logic [DATA_W-1:0] x_wdata = '0, x_drd = '0, x_erd = '0;
    bit                g_d = 0, g_e = 0, g_l = 0;

    always @(negedge clk) begin
        if (started) begin
            bit wd, we_, wl, xdv, xev;
            wd = 0; we_ = 0; wl = 0; xdv = 0; xev = 0;
            if (!rst) begin
                if (disp_req) wd = 1;
                else if (edge_req && load_req) begin
                    if (edge_served_last) wl = 1; else we_ = 1;
                end
                else if (edge_req) we_ = 1;
                else if (load_req) wl = 1;
            end
            chk("disp_gnt", disp_gnt, wd);
            chk("edge_gnt", edge_gnt, we_);
            chk("load_gnt", load_gnt, wl);
            chk("mem_en", mem_en, x_en);
            if (x_en) begin
                chk("mem_we", mem_we, x_we);
                chk("mem_addr", mem_addr, x_addr);
                if (x_we) chk("mem_wdata", mem_wdata, x_wdata);
            end
            if (rq.size() > 0 && rq[0].due == ncyc) begin
                if (rq[0].to_edge) begin xev = 1; x_erd = rq[0].data; end
                else begin xdv = 1; x_drd = rq[0].data; end
                void'(rq.pop_front());
            end
            chk("disp_rvalid", disp_rvalid, xdv);
            chk("edge_rvalid", edge_rvalid, xev);
            chk("disp_rdata", disp_rdata, x_drd);
            chk("edge_rdata", edge_rdata, x_erd);
            // State as it will be after this clock edge
            g_d = wd; g_e = we_; g_l = wl;
            if (rst) begin
                x_en = 0; x_we = 0; x_addr = '0; x_wdata = '0;
                x_drd = '0; x_erd = '0; edge_served_last = 0;
                rq.delete();
            end else begin
                x_en = wd | we_ | wl;
                x_we = wl | (we_ & edge_we);
                if (wd) begin
                    x_addr = disp_addr;
                    rq.push_back('{ncyc + 2 + RD_LAT, 1'b0, ref_mem[disp_addr]});
                end else if (we_) begin
                    x_addr = edge_addr;
                    x_wdata = edge_wdata;
                    edge_served_last = 1;
                    if (edge_we) ref_mem[edge_addr] = edge_wdata;
                    else rq.push_back('{ncyc + 2 + RD_LAT, 1'b1, ref_mem[edge_addr]});
                end else if (wl) begin
                    x_addr = load_addr;
                    x_wdata = load_wdata;
                    edge_served_last = 0;
                    ref_mem[load_addr] = load_wdata;
                end
            end
            ncyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int a = 0; a < MEMSZ; a++) begin
            sram[a] = DATA_W'(a + 'h40);
            ref_mem[a] = DATA_W'(a + 'h40);
        end
        sram[16] = 8'hA5;
        ref_mem[16] = 8'hA5;
        rst = 1; disp_req = 0; edge_req = 0; load_req = 0; edge_we = 0;
        disp_addr = '0; edge_addr = '0; load_addr = '0; edge_wdata = '0; load_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst mem_en", mem_en, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst disp_rvalid", disp_rvalid, 0);
        chk("rst edge_rdata", edge_rdata, 0);
        started = 1;
        rst = 0;

        // Single display read
        step();
        disp_req = 1; disp_addr = 'h10;
        #1 chk("t1 disp_gnt", disp_gnt, 1);
        step();
        disp_req = 0;
        #1 chk("t1 mem_en", mem_en, 1);
        chk("t1 mem_addr", mem_addr, 'h10);
        step(); step();
        #1 chk("t1 disp_rvalid", disp_rvalid, 1);
        chk("t1 disp_rdata", disp_rdata, 'hA5);

        // Edge and load contend: strict alternation starting with edge
        step();
        edge_req = 1; edge_we = 1; edge_addr = 'h200; edge_wdata = 'h11;
        load_req = 1; load_addr = 'h201; load_wdata = 'h22;
        for (int i = 0; i < 6; i++) begin
            #1 chk("t2 edge_gnt", edge_gnt, (i % 2 == 0));
            chk("t2 load_gnt", load_gnt, (i % 2 == 1));
            step();
        end
        edge_req = 0; load_req = 0;

        // All three request: display first, then edge, then load
        step();
        disp_req = 1; disp_addr = 'h20;
        edge_req = 1; edge_we = 0; edge_addr = 'h21;
        load_req = 1; load_addr = 'h300; load_wdata = 'h33;
        for (int i = 0; i < 4; i++) begin
            #1 chk("t3 disp_gnt", disp_gnt, 1);
            chk("t3 edge_gnt", edge_gnt, 0);
            step();
        end
        disp_req = 0;
        #1 chk("t3 edge first", edge_gnt, 1);
        chk("t3 load waits", load_gnt, 0);
        step();
        edge_req = 0;
        #1 chk("t3 load next", load_gnt, 1);
        step();
        load_req = 0;

        // Load write then edge read of the same word
        step();
        load_req = 1; load_addr = 'h100; load_wdata = 'h3C;
        #1 chk("t4 load_gnt", load_gnt, 1);
        step();
        load_req = 0;
        edge_req = 1; edge_we = 0; edge_addr = 'h100;
        #1 chk("t4 edge_gnt", edge_gnt, 1);
        step();
        edge_req = 0;
        step(); step();
        #1 chk("t4 edge_rvalid", edge_rvalid, 1);
        chk("t4 edge_rdata", edge_rdata, 'h3C);
        chk("t4 disp_rvalid", disp_rvalid, 0);

        // Interleaved display/edge reads return in grant order
        step();
        disp_req = 1; disp_addr = 'h1;
        step();
        disp_req = 0; edge_req = 1; edge_we = 0; edge_addr = 'h2;
        step();
        edge_req = 0; disp_req = 1; disp_addr = 'h3;
        step();
        disp_req = 0;
        #1 chk("t5 disp_rvalid 1", disp_rvalid, 1);
        chk("t5 disp_rdata 1", disp_rdata, 'h41);
        step();
        #1 chk("t5 edge_rvalid", edge_rvalid, 1);
        chk("t5 edge_rdata", edge_rdata, 'h42);
        step();
        #1 chk("t5 disp_rvalid 2", disp_rvalid, 1);
        chk("t5 disp_rdata 2", disp_rdata, 'h43);

        // Reset right after an edge read grant
        step();
        edge_req = 1; edge_we = 0; edge_addr = 'h5;
        #1 chk("t6 edge_gnt", edge_gnt, 1);
        step();
        edge_req = 0; rst = 1;
        step();
        rst = 0;
        #1 chk("t6 mem_en", mem_en, 0);
        chk("t6 mem_addr", mem_addr, 0);
        chk("t6 disp_rdata", disp_rdata, 0);
        chk("t6 edge_rdata", edge_rdata, 0);
        step();
        #1 chk("t6 edge_rvalid", edge_rvalid, 0);
        edge_req = 1; load_req = 1; edge_addr = 'h6; load_addr = 'h7;
        #1 chk("t6 rr edge", edge_gnt, 1);
        step();
        edge_req = 0;
        #1 chk("t6 rr load", load_gnt, 1);
        step();
        load_req = 0;

        // Random traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            step();
            rst = ($urandom_range(0, 199) == 0);
            if (!disp_req || g_d) begin
                disp_req = ($urandom_range(0, 9) < 3);
                disp_addr = ADDR_W'($urandom_range(0, 63));
            end
            if (!edge_req || g_e) begin
                edge_req = $urandom_range(0, 1);
                edge_we = $urandom_range(0, 1);
                edge_addr = ADDR_W'($urandom_range(0, 63));
                edge_wdata = DATA_W'($urandom);
            end
            if (!load_req || g_l) begin
                load_req = $urandom_range(0, 1);
                load_addr = ADDR_W'($urandom_range(0, 63));
                load_wdata = DATA_W'($urandom);
            end
        end
        step();
        rst = 0; disp_req = 0; edge_req = 0; load_req = 0;
        repeat (RD_LAT + 4) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Single-port frame-buffer arbiter for the edge-detection accelerator. It shares one synchronous SRAM port between three requesters:
- VGA scanout read path (display);
- Sobel edge engine read/write path (edge);
- image loader write path (load).

Display always has absolute priority so scanout never underflows. Edge and load share the remaining cycles in round-robin order. Read data returns to the correct requester through a tagged return pipeline.

## Interface
Parameters:
- ADDR_W, 15, frame-buffer word address width (160x120 = 19200 words)
- DATA_W, 8, pixel word width
- RD_LAT, 1, SRAM read latency in cycles, mem_en to mem_rdata valid; legal range 1..4

Ports:
- clk  in  1  system clock (HSOSC domain)
- rst  in  1  synchronous, active-high reset
- disp_req  in  1  display read request
- disp_addr  in  ADDR_W  display read address
- disp_gnt  out  1  display request accepted this cycle
- disp_rvalid  out  1  display read data valid
- disp_rdata  out  DATA_W  display read data
- edge_req  in  1  edge engine request
- edge_we  in  1  edge request is a write (1) or read (0)
- edge_addr  in  ADDR_W  edge address
- edge_wdata  in  DATA_W  edge write data
- edge_gnt  out  1  edge request accepted this cycle
- edge_rvalid  out  1  edge read data valid
- edge_rdata  out  DATA_W  edge read data
- load_req  in  1  loader write request
- load_addr  in  ADDR_W  loader address
- load_wdata  in  DATA_W  loader write data
- load_gnt  out  1  loader request accepted this cycle
- mem_en  out  1  SRAM access strobe
- mem_we  out  1  SRAM write enable
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data

## Operation
- Request rules:
  - A requester holds req high with stable addr/we/wdata until it sees gnt.
  - It may drop req only in the cycle after gnt.
  - At most one gnt is asserted per cycle.
- Priority:
  - disp_req high: disp_gnt=1, no other grant that cycle.
  - Otherwise edge and load arbitrate by round-robin. Pointer rr=0 favours edge, rr=1 favours load.
  - A single requester is granted regardless of rr.
  - When both request, the favoured one wins.
  - After an edge or load grant, rr points to the other requester. Display grants leave rr unchanged.
- Grants (disp_gnt, edge_gnt, load_gnt) are combinational from req, rr and rst. All gnt = 0 while rst = 1.
- Command stage: the granted command is registered into mem_en/mem_we/mem_addr/mem_wdata one cycle after gnt.
  - mem_en = 0 in cycles with no grant.
  - mem_we = 1 for load grants and for edge grants with edge_we = 1.
- Return pipeline:
  - A tag shift register of depth RD_LAT tracks each issued command: {valid, owner: disp/edge}. Writes and idle cycles carry valid = 0.
  - When a tag exits the pipeline, mem_rdata is registered into the owner's rdata and that owner's rvalid pulses for 1 cycle.
  - rdata holds its last value when rvalid = 0.
- Reads complete in grant order, one per cycle maximum. No reordering and no back-pressure on returns.

## Timing
- Reset values: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, all rvalid=0, all rdata=0, rr=0, tag pipeline cleared.
- Latency, grant at cycle t:
  - mem_en at t+1;
  - mem_rdata sampled at t+1+RD_LAT;
  - rvalid/rdata at t+2+RD_LAT (t+3 with RD_LAT=1).
- Throughput: one access per cycle sustained. Back-to-back grants to any mix of owners are legal.
- Edge read-after-write to the same address, granted in consecutive cycles, returns the new data. SRAM write-first or issue ordering guarantees this.
- Simultaneous events:
  - All three request: display wins, rr unchanged.
  - Edge and load both pending under a continuous display stream: both starve. The display controller guarantees blanking gaps.
- Reset mid-operation: rst=1 clears in-flight tags. No rvalid is asserted for reads granted before or during reset. Outputs hold reset values until the first grant after rst falls.
- Arithmetic: no address arithmetic. Addresses pass through unmodified; out-of-range addresses are the requester's responsibility.

## Test plan
- Reset, then disp_req at addr 0x0010 with mem holding 0xA5 -> disp_gnt same cycle, mem_en=1 and mem_addr=0x0010 next cycle, disp_rvalid=1 with disp_rdata=0xA5 three cycles after grant (RD_LAT=1).
- edge_req and load_req held together for 6 cycles with no display -> grants alternate edge, load, edge, load, edge, load; one grant per cycle.
- All three request for 4 cycles, then disp_req drops -> 4 display grants, then edge granted first (rr=0 preserved), then load.
- Load write 0x3C to 0x0100, then edge read 0x0100 next cycle -> edge_rvalid pulses once with edge_rdata=0x3C; disp_rvalid stays 0.
- Interleaved disp read 0x0001, edge read 0x0002, disp read 0x0003 (mem = addr+0x40) -> rvalid pulses in order: disp 0x41, edge 0x42, disp 0x43, on consecutive cycles.
- Grant edge read, assert rst for 1 cycle the next cycle -> no edge_rvalid ever, all outputs at reset values during and after reset, rr=0.
